// File: rtl/regfile_bus_unit_pkg.sv
// Shared definitions for the register file / bus unit: FSM state codes, width defaults, select type.
// No logic here; latency and backpressure are properties of the modules that import it.
package regfile_bus_unit_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RD_WAIT = 2'd1;
  localparam state_t ST_WR_WAIT = 2'd2;

  // One-hot register select at the default register count.
  typedef logic [NUM_REGS_DEF-1:0] sel_t;

  function automatic logic state_busy(input state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/regfile_bus_unit_gate_or_bus.sv
// N-way AND-gate / OR-reduce bus driver; zero latency, no backpressure.
// Multiple selects wire-OR together; no select drives all zeros.
module gate_or_bus #(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic [N-1:0][W-1:0] data_i,
  input  logic [N-1:0]        sel_i,
  output logic [W-1:0]        bus_o
);

  always_comb begin
    bus_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i[i]) bus_o = bus_o | data_i[i];
    end
  end

endmodule

// File: rtl/regfile_bus_unit.sv
// Register file with A/B bus gates (zero latency), registered stores, MAR/MDR and a req/ack memory FSM.
// Memory side stalls on mem_ack up to TIMEOUT cycles; requests or MDR stores while busy are dropped and flag err.
module regfile_bus_unit
  import regfile_bus_unit_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REGS-1:0] ra_sel,
  input  logic [NUM_REGS-1:0] rb_sel,
  input  logic                mda,
  input  logic [DATA_W-1:0]   s_bus,
  input  logic [NUM_REGS-1:0] sr,
  input  logic                sma,
  input  logic                smd,
  input  logic                mem_rd,
  input  logic                mem_wr,
  output logic [DATA_W-1:0]   a_bus,
  output logic [DATA_W-1:0]   b_bus,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]               mar_q, mar_d;
  logic [DATA_W-1:0]               mdr_q, mdr_d;
  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;
  logic [DATA_W-1:0]               a_gate, b_gate;

  gate_or_bus #(.N(NUM_REGS), .W(DATA_W)) u_gate_a (
    .data_i (regs_q),
    .sel_i  (ra_sel),
    .bus_o  (a_gate)
  );

  gate_or_bus #(.N(NUM_REGS), .W(DATA_W)) u_gate_b (
    .data_i (regs_q),
    .sel_i  (rb_sel),
    .bus_o  (b_gate)
  );

  assign a_bus     = a_gate | (mda ? mdr_q : '0);
  assign b_bus     = b_gate;
  assign busy      = state_busy(state_q);
  assign mem_req   = busy;
  assign mem_we    = (state_q == ST_WR_WAIT);
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = sr[i] ? s_bus : regs_q[i];
    end
    mar_d = sma ? s_bus : mar_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mdr_d   = mdr_q;
    done_d  = 1'b0;
    err_d   = err_q;

    // MDR is frozen during a transfer so mem_wdata stays stable.
    if (smd) begin
      if (busy) err_d = 1'b1;
      else      mdr_d = s_bus;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (mem_rd && mem_wr) err_d   = 1'b1;
        else if (mem_rd)      state_d = ST_RD_WAIT;
        else if (mem_wr)      state_d = ST_WR_WAIT;
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (mem_rd || mem_wr) err_d = 1'b1;
        // Ack wins over timeout on the final wait cycle.
        if (mem_ack) begin
          if (state_q == ST_RD_WAIT) mdr_d = mem_rdata;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_regfile_bus_unit.sv
// Directed bench for regfile_bus_unit: bus gates, stores, memory read/write, timeout, illegal events, reset.
module tb_regfile_bus_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ra_sel, rb_sel, sr;
  logic        mda, sma, smd, mem_rd, mem_wr, mem_ack;
  logic [15:0] s_bus, mem_rdata;
  logic [15:0] a_bus, b_bus, mem_addr, mem_wdata;
  logic        mem_req, mem_we, busy, done, err;

  int errors = 0;
  int checks = 0;

  regfile_bus_unit #(.DATA_W(16), .NUM_REGS(8), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_sel    (ra_sel),
    .rb_sel    (rb_sel),
    .mda       (mda),
    .s_bus     (s_bus),
    .sr        (sr),
    .sma       (sma),
    .smd       (smd),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ra_sel = '0; rb_sel = '0; sr = '0; mda = 0; sma = 0; smd = 0;
    mem_rd = 0; mem_wr = 0; mem_ack = 0; s_bus = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    ra_sel = 8'hFF; rb_sel = 8'hFF; mda = 1;
    #1;
    checks++; if (a_bus !== 16'h0000) begin errors++; $display("FAIL reset_a_bus got=%h exp=0000", a_bus); end
    checks++; if (b_bus !== 16'h0000) begin errors++; $display("FAIL reset_b_bus got=%h exp=0000", b_bus); end
    checks++; if ({mem_req, mem_we, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, busy, done, err}); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mar got=%h exp=0000", mem_addr); end
    rst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_store_gate();
    sr = 8'h05; s_bus = 16'hA5A5;
    tick();
    sr = '0; s_bus = '0; ra_sel = 8'h01;
    #1;
    checks++; if (a_bus !== 16'hA5A5) begin errors++; $display("FAIL store_a_r0 got=%h exp=A5A5", a_bus); end
    rb_sel = 8'h05;
    #1;
    checks++; if (b_bus !== 16'hA5A5) begin errors++; $display("FAIL store_b_r0r2 got=%h exp=A5A5", b_bus); end
    ra_sel = 8'h02;
    #1;
    checks++; if (a_bus !== 16'h0000) begin errors++; $display("FAIL store_a_r1 got=%h exp=0000", a_bus); end
    ra_sel = '0; rb_sel = '0;
    #1;
    checks++; if ({a_bus, b_bus} !== 32'h0) begin errors++; $display("FAIL nosel_buses got=%h exp=00000000", {a_bus, b_bus}); end
  endtask

  task automatic test_wire_or_no_bypass();
    sr = 8'h02; s_bus = 16'h00F0;
    tick();
    sr = 8'h04; s_bus = 16'h0F00;
    tick();
    sr = '0; ra_sel = 8'h06;
    #1;
    checks++; if (a_bus !== 16'h0FF0) begin errors++; $display("FAIL wire_or got=%h exp=0FF0", a_bus); end
    sr = 8'h02; s_bus = 16'hFFFF;
    #1;
    checks++; if (a_bus !== 16'h0FF0) begin errors++; $display("FAIL no_bypass got=%h exp=0FF0", a_bus); end
    tick();
    sr = '0;
    #1;
    checks++; if (a_bus !== 16'hFFFF) begin errors++; $display("FAIL store_next_cycle got=%h exp=FFFF", a_bus); end
    clear_inputs();
  endtask

  task automatic test_read();
    int req_cycles = 0;
    s_bus = 16'h0040; sma = 1;
    tick();
    sma = 0; mem_rd = 1;
    tick();
    mem_rd = 0;
    checks++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL rd_addr got=%h exp=0040", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_we got=%b exp=0", mem_we); end
    for (int c = 0; c < 3; c++) begin
      if (mem_req === 1'b1) req_cycles++;
      if (c == 2) begin mem_ack = 1; mem_rdata = 16'h1234; end
      tick();
    end
    mem_ack = 0; mem_rdata = '0;
    checks++; if (req_cycles != 3) begin errors++; $display("FAIL rd_req_cycles got=%0d exp=3", req_cycles); end
    checks++; if ({mem_req, busy, done} !== 3'b001) begin
      errors++; $display("FAIL rd_done got=%b exp=001 (req,busy,done)", {mem_req, busy, done}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rd_done_pulse got=%b exp=0", done); end
    mda = 1;
    #1;
    checks++; if (a_bus !== 16'h1234) begin errors++; $display("FAIL rd_mdr got=%h exp=1234", a_bus); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", err); end
    mda = 0;
  endtask

  task automatic test_write_imm();
    s_bus = 16'hBEEF; smd = 1;
    tick();
    smd = 0; mem_wr = 1;
    tick();
    mem_wr = 0;
    checks++; if ({mem_req, mem_we, busy} !== 3'b111) begin
      errors++; $display("FAIL wr_req got=%b exp=111 (req,we,busy)", {mem_req, mem_we, busy}); end
    checks++; if (mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_wdata got=%h exp=BEEF", mem_wdata); end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    checks++; if ({mem_req, busy, done} !== 3'b001) begin
      errors++; $display("FAIL wr_done got=%b exp=001 (req,busy,done)", {mem_req, busy, done}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_timeout();
    int n = 0;
    int saw_done = 0;
    mem_rd = 1;
    tick();
    mem_rd = 0;
    for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
      n++;
      if (done === 1'b1) saw_done++;
      tick();
    end
    if (done === 1'b1) saw_done++;
    checks++; if (n != 15) begin errors++; $display("FAIL to_req_cycles got=%0d exp=15", n); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", err); end
    checks++; if (saw_done != 0) begin errors++; $display("FAIL to_no_done got=%0d exp=0", saw_done); end
    mda = 1;
    #1;
    checks++; if (a_bus !== 16'hBEEF) begin errors++; $display("FAIL to_mdr got=%h exp=BEEF", a_bus); end
    mda = 0;
  endtask

  task automatic test_illegal_and_reset();
    do_reset();
    mem_rd = 1; mem_wr = 1;
    tick();
    mem_rd = 0; mem_wr = 0;
    checks++; if ({busy, mem_req, err} !== 3'b001) begin
      errors++; $display("FAIL both_strobes got=%b exp=001 (busy,req,err)", {busy, mem_req, err}); end

    do_reset();
    mem_rd = 1;
    tick();
    mem_rd = 0; mem_wr = 1;
    tick();
    mem_wr = 0;
    checks++; if ({busy, mem_we, err} !== 3'b101) begin
      errors++; $display("FAIL wr_while_busy got=%b exp=101 (busy,we,err)", {busy, mem_we, err}); end

    do_reset();
    mem_rd = 1;
    tick();
    mem_rd = 0; smd = 1; s_bus = 16'h1111;
    tick();
    smd = 0; mda = 1;
    #1;
    checks++; if (a_bus !== 16'h0000) begin errors++; $display("FAIL smd_busy_mdr got=%h exp=0000", a_bus); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL smd_busy_err got=%b exp=1", err); end
    mda = 0;

    do_reset();
    sr = 8'hFF; sma = 1; smd = 1; s_bus = 16'h1357;
    tick();
    sr = '0; sma = 0; smd = 0; mem_rd = 1;
    tick();
    mem_rd = 0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL pre_rst_req got=%b exp=1", mem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_req, busy, done, err} !== 4'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got=%b exp=0000", {mem_req, busy, done, err}); end
    ra_sel = 8'hFF; rb_sel = 8'hFF; mda = 1;
    #1;
    checks++; if ({a_bus, b_bus, mem_addr} !== 48'h0) begin
      errors++; $display("FAIL rst_mid_regs got=%h exp=0", {a_bus, b_bus, mem_addr}); end
    rst_n = 1'b1;
    clear_inputs();
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_no_done got=%b exp=0", done); end
  endtask

  initial begin
    test_reset();
    test_store_gate();
    test_wire_or_no_bypass();
    test_read();
    test_write_imm();
    test_timeout();
    test_illegal_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
